// File: rtl/usr_pkg.sv
// Shared types for the universal shift register with sequencer.
// Holds the operation encodings, FSM states and the mode decoder.
package usr_pkg;

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHR  = 3'b001,
        M_SHL  = 3'b010,
        M_LOAD = 3'b011,
        M_ASR  = 3'b100,
        M_ROR  = 3'b101,
        M_ROL  = 3'b110,
        M_RSVD = 3'b111
    } usr_mode_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } usr_state_t;

    // Rotates collapse to HOLD when the rotate option is not built.
    function automatic usr_mode_t usr_decode(
        input logic [2:0] m,
        input bit         rot_en
    );
        usr_mode_t r;
        r = usr_mode_t'(m);
        unique case (1'b1)
            (r == M_RSVD):                    r = M_HOLD;
            (!rot_en && (r == M_ROR)):        r = M_HOLD;
            (!rot_en && (r == M_ROL)):        r = M_HOLD;
            default:                          r = r;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usr_seq_if.sv
// Control/data bundle between a client and usr_seq.
// master drives the operation request, slave is the register.
interface usr_seq_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
) ();

    logic [2:0]         mode;
    logic [WIDTH-1:0]   pin;
    logic               lin;
    logic               rin;
    logic               start;
    logic [COUNT_W-1:0] count;
    logic [WIDTH-1:0]   out;
    logic               sout_r;
    logic               sout_l;
    logic               busy;
    logic               done;

    modport master (
        output mode, pin, lin, rin, start, count,
        input  out, sout_r, sout_l, busy, done
    );

    modport slave (
        input  mode, pin, lin, rin, start, count,
        output out, sout_r, sout_l, busy, done
    );

endinterface

// File: rtl/usr_cell.sv
// One bit of the shift register: next-state mux and flop.
// All neighbour/serial/rotate sources arrive pre-wired from the top.
module usr_cell
    import usr_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  usr_mode_t op,
    input  logic      d,
    input  logic      shr_in,
    input  logic      shl_in,
    input  logic      asr_in,
    input  logic      ror_in,
    input  logic      rol_in,
    output logic      q
);

    logic nxt;

    always_comb begin
        nxt = q;
        case (op)
            M_SHR:   nxt = shr_in;
            M_SHL:   nxt = shl_in;
            M_LOAD:  nxt = d;
            M_ASR:   nxt = asr_in;
            M_ROR:   nxt = ror_in;
            M_ROL:   nxt = rol_in;
            default: nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/usr_seq.sv
// Universal shift register with start/busy/done shift sequencer.
// Define USR_SEQ_ROTATE_EN to implement ROR/ROL (else they hold).
module usr_seq
    import usr_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
) (
    input logic    clk,
    input logic    reset,
    usr_seq_if.slave bus
);

`ifdef USR_SEQ_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    usr_state_t         state;
    usr_state_t         state_n;
    usr_mode_t          lmode;
    usr_mode_t          op;
    logic [COUNT_W-1:0] rem;
    logic               done_q;
    logic               busy_c;
    logic               last;
    logic               go;

    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   shr_v;
    logic [WIDTH-1:0]   shl_v;
    logic [WIDTH-1:0]   asr_v;
    logic [WIDTH-1:0]   ror_v;
    logic [WIDTH-1:0]   rol_v;

    assign go   = (state == S_IDLE) && bus.start;
    assign last = (rem == COUNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (bus.start && (bus.count != '0)) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // A start edge itself performs no operation on the register.
    always_comb begin
        op     = M_HOLD;
        busy_c = 1'b0;
        unique case (state)
            S_IDLE: begin
                op = bus.start ? M_HOLD : usr_decode(bus.mode, ROT_EN);
            end
            S_RUN: begin
                op     = lmode;
                busy_c = 1'b1;
            end
            default: begin
                op     = M_HOLD;
                busy_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lmode  <= M_HOLD;
            rem    <= '0;
            done_q <= 1'b0;
        end else if (go) begin
            lmode  <= usr_decode(bus.mode, ROT_EN);
            rem    <= bus.count;
            done_q <= (bus.count == '0);
        end else if (state == S_RUN) begin
            rem    <= rem - COUNT_W'(1);
            done_q <= last;
        end else begin
            done_q <= 1'b0;
        end
    end

    assign shr_v = {bus.rin,    q[WIDTH-1:1]};
    assign asr_v = {q[WIDTH-1], q[WIDTH-1:1]};
    assign ror_v = {q[0],       q[WIDTH-1:1]};
    assign shl_v = {q[WIDTH-2:0], bus.lin};
    assign rol_v = {q[WIDTH-2:0], q[WIDTH-1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usr_cell u_cell (
            .clk    (clk),
            .reset  (reset),
            .op     (op),
            .d      (bus.pin[i]),
            .shr_in (shr_v[i]),
            .shl_in (shl_v[i]),
            .asr_in (asr_v[i]),
            .ror_in (ror_v[i]),
            .rol_in (rol_v[i]),
            .q      (q[i])
        );
    end

    assign bus.out    = q;
    assign bus.sout_r = q[0];
    assign bus.sout_l = q[WIDTH-1];
    assign bus.busy   = busy_c;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_usr_seq.sv
// Bench for usr_seq: directed table, corner sequences, random vs model.
// Honours USR_SEQ_ROTATE_EN in its reference model.
module tb_usr_seq;

    localparam int W  = 8;
    localparam int CW = 4;

`ifdef USR_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic clk;
    logic reset;

    usr_seq_if #(.WIDTH(W), .COUNT_W(CW)) bus ();

    usr_seq #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec;
    int errs;

    logic [W-1:0] m_q;
    logic [2:0]   m_mode;
    int           m_rem;
    logic         m_done;

    typedef struct {
        logic [2:0]   mode;
        logic [W-1:0] pin;
        logic         lin;
        logic         rin;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [W-1:0] apply(
        input logic [2:0]   m,
        input logic [W-1:0] v,
        input logic         li,
        input logic         ri,
        input logic [W-1:0] p
    );
        logic signed [W-1:0] s;
        s = v;
        case (m)
            3'd1: return (v >> 1) | (W'(ri) << (W - 1));
            3'd2: return (v << 1) | W'(li);
            3'd3: return p;
            3'd4: return W'(s >>> 1);
            3'd5: return ROT ? ((v >> 1) | (v << (W - 1))) : v;
            3'd6: return ROT ? ((v << 1) | (v >> (W - 1))) : v;
            default: return v;
        endcase
    endfunction

    task automatic model_edge();
        if (m_rem > 0) begin
            m_q = apply(m_mode, m_q, bus.lin, bus.rin, bus.pin);
            m_rem--;
            m_done = (m_rem == 0);
        end else if (bus.start) begin
            m_mode = bus.mode;
            m_rem  = int'(bus.count);
            m_done = (bus.count == 0);
        end else begin
            m_q    = apply(bus.mode, m_q, bus.lin, bus.rin, bus.pin);
            m_done = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_q    = '0;
        m_mode = '0;
        m_rem  = 0;
        m_done = 1'b0;
    endtask

    task automatic chk(input string nm);
        logic eb;
        eb = (m_rem > 0);
        vec++;
        if (bus.out !== m_q || bus.busy !== eb || bus.done !== m_done ||
            bus.sout_r !== m_q[0] || bus.sout_l !== m_q[W-1]) begin
            errs++;
            $display("FAIL %s: got out=%h busy=%b done=%b sr=%b sl=%b, want out=%h busy=%b done=%b sr=%b sl=%b",
                nm, bus.out, bus.busy, bus.done, bus.sout_r, bus.sout_l,
                m_q, eb, m_done, m_q[0], m_q[W-1]);
        end
    endtask

    task automatic expc(input string nm, input logic [W-1:0] o,
                        input logic b, input logic d);
        vec++;
        if (bus.out !== o || bus.busy !== b || bus.done !== d) begin
            errs++;
            $display("FAIL %s: got out=%h busy=%b done=%b, want out=%h busy=%b done=%b",
                nm, bus.out, bus.busy, bus.done, o, b, d);
        end
    endtask

    task automatic cyc(input string nm);
        @(posedge clk);
        model_edge();
        #1;
        chk(nm);
    endtask

    task automatic drive(input logic [2:0] m, input logic [W-1:0] p,
                         input logic li, input logic ri,
                         input logic st, input logic [CW-1:0] c);
        bus.mode  = m;
        bus.pin   = p;
        bus.lin   = li;
        bus.rin   = ri;
        bus.start = st;
        bus.count = c;
    endtask

    task automatic rst_pulse(input string nm);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk(nm);
        expc({nm, "_abs"}, '0, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        vec   = 0;
        errs  = 0;
        reset = 1'b0;
        drive(3'd0, '0, 1'b0, 1'b0, 1'b0, '0);
        model_reset();

        tbl[0]  = '{3'd3, 8'hA5, 1'b0, 1'b0, 8'hA5};
        tbl[1]  = '{3'd1, 8'h00, 1'b0, 1'b1, 8'hD2};
        tbl[2]  = '{3'd3, 8'hA5, 1'b0, 1'b0, 8'hA5};
        tbl[3]  = '{3'd2, 8'hFF, 1'b0, 1'b1, 8'h4A};
        tbl[4]  = '{3'd2, 8'h00, 1'b1, 1'b0, 8'h95};
        tbl[5]  = '{3'd3, 8'h80, 1'b0, 1'b0, 8'h80};
        tbl[6]  = '{3'd4, 8'h00, 1'b0, 1'b1, 8'hC0};
        tbl[7]  = '{3'd4, 8'h00, 1'b1, 1'b0, 8'hE0};
        tbl[8]  = '{3'd1, 8'h00, 1'b1, 1'b0, 8'h70};
        tbl[9]  = '{3'd3, 8'h96, 1'b0, 1'b0, 8'h96};
        tbl[10] = '{3'd6, 8'h00, 1'b1, 1'b1, ROT ? 8'h2D : 8'h96};
        tbl[11] = '{3'd5, 8'h00, 1'b1, 1'b1, 8'h96};
        tbl[12] = '{3'd7, 8'h3C, 1'b1, 1'b1, 8'h96};
        tbl[13] = '{3'd0, 8'hC3, 1'b1, 1'b1, 8'h96};

        #3;
        vec++;
        if (bus.out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: got out=%h busy=%b done=%b, want 00 0 0",
                bus.out, bus.busy, bus.done);
        end
        #4 reset = 1'b1;

        // Directed table in direct mode
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].mode, tbl[i].pin, tbl[i].lin, tbl[i].rin, 1'b0, '0);
            cyc($sformatf("tbl%0d", i));
            expc($sformatf("tbl%0d_exp", i), tbl[i].exp, 1'b0, 1'b0);
        end
        drive(3'd3, 8'hA5, 1'b0, 1'b0, 1'b0, '0);
        cyc("ld_a5");
        drive(3'd1, 8'h00, 1'b0, 1'b1, 1'b0, '0);
        cyc("shr_a5");
        vec++;
        if (bus.sout_r !== 1'b0 || bus.sout_l !== 1'b1) begin
            errs++;
            $display("FAIL sout: got r=%b l=%b, want r=0 l=1", bus.sout_r, bus.sout_l);
        end

        // Reset mid-run while out=5A and busy
        drive(3'd3, 8'h5A, 1'b0, 1'b0, 1'b0, '0);
        cyc("ld_5a");
        drive(3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
        cyc("st_hold5");
        drive(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        cyc("hold_run");
        expc("busy_5a", 8'h5A, 1'b1, 1'b0);
        rst_pulse("rst_mid");
        for (int i = 0; i < 6; i++) cyc("post_rst");

        // ASR sequenced run of 3
        drive(3'd3, 8'h80, 1'b0, 1'b0, 1'b0, '0);
        cyc("ld_80");
        drive(3'd4, 8'h00, 1'b0, 1'b1, 1'b1, 4'd3);
        cyc("asr_e0");
        expc("asr_e0x", 8'h80, 1'b1, 1'b0);
        drive(3'd0, 8'h00, 1'b0, 1'b1, 1'b0, '0);
        cyc("asr1");
        expc("asr1x", 8'hC0, 1'b1, 1'b0);
        cyc("asr2");
        expc("asr2x", 8'hE0, 1'b1, 1'b0);
        cyc("asr3");
        expc("asr3x", 8'hF0, 1'b0, 1'b1);
        cyc("asr4");
        expc("asr4x", 8'hF0, 1'b0, 1'b0);

        // ROL sequenced run of 4
        drive(3'd3, 8'h96, 1'b0, 1'b0, 1'b0, '0);
        cyc("ld_96");
        drive(3'd6, 8'h00, 1'b0, 1'b0, 1'b1, 4'd4);
        cyc("rol_e0");
        drive(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc("rol_run");
        expc("rol4", ROT ? 8'h69 : 8'h96, 1'b0, 1'b1);

        // SHR x5 with start raised mid-run
        drive(3'd3, 8'hFF, 1'b0, 1'b0, 1'b0, '0);
        cyc("ld_ff");
        drive(3'd1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
        cyc("shr5_e0");
        drive(3'd3, 8'h00, 1'b1, 1'b0, 1'b1, 4'd2);
        cyc("shr5_restart");
        drive(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc("shr5_run");
        expc("shr5", 8'h07, 1'b0, 1'b1);
        cyc("shr5_idle");

        // count == 0
        drive(3'd2, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0);
        cyc("c0_e0");
        expc("c0_done", 8'h07, 1'b0, 1'b1);
        drive(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        cyc("c0_after");
        expc("c0_after_x", 8'h07, 1'b0, 1'b0);

        // Reset after 2 shifts of a count 5 run
        drive(3'd3, 8'hFF, 1'b0, 1'b0, 1'b0, '0);
        cyc("ld_ff2");
        drive(3'd1, 8'h00, 1'b0, 1'b1, 1'b1, 4'd5);
        cyc("abort_e0");
        drive(3'd0, 8'h00, 1'b0, 1'b1, 1'b0, '0);
        cyc("abort1");
        cyc("abort2");
        rst_pulse("abort_rst");
        for (int i = 0; i < 6; i++) begin
            cyc("abort_post");
            expc("abort_nodone", 8'h00, 1'b0, 1'b0);
        end

        // Random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            drive(3'($urandom_range(0, 7)), W'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 5) == 0),
                  CW'($urandom_range(0, 15)));
            if ($urandom_range(0, 99) == 0) begin
                rst_pulse("rnd_rst");
            end
            cyc("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
